agu_multi_lane: RTL
===================

// Module: agu_multi_lane
// PURPOSE
//  Successor address-generation unit for the 2-issue core. Accepts up to NUM_LANES memory ops
//  per cycle from the issue stage, computes the effective address (base + imm), decodes size,
//  byte enables and misalignment, and aligns store data. Queues results in an in-order FIFO
//  that drains one request per cycle to the LSU over a valid/ready handshake.
// PARAMETERS
//  NUM_LANES  2   issue lanes into the AGU; lane 0 is older than lane 1
//  XLEN       32  address/data width
//  DEPTH      4   FIFO entries; power of two, >= NUM_LANES
// PORTS
//  i_clk          in   1                clock; all state changes on rising edge
//  i_rst          in   1                synchronous, active-high reset
//  i_flush        in   1                pipeline flush (mispredict); clears queue
//  i_valid        in   NUM_LANES        per-lane op valid
//  i_base         in   NUM_LANES*XLEN   rs1 value per lane
//  i_imm          in   NUM_LANES*XLEN   sign-extended offset per lane
//  i_funct3       in   NUM_LANES*3      RV32 load/store funct3 per lane
//  i_is_store     in   NUM_LANES        1=store, 0=load
//  i_store_data   in   NUM_LANES*XLEN   rs2 value per lane (stores)
//  i_rd_addr      in   NUM_LANES*5      load destination register
//  i_wr_en        in   NUM_LANES        load writes rd
//  o_ready        out  1                AGU can accept a full issue group this cycle
//  o_valid        out  1                FIFO head valid toward LSU
//  i_ready        in   1                LSU accepts head this cycle
//  o_addr         out  XLEN             effective address
//  o_byte_en      out  4                byte-lane enables
//  o_funct3       out  3                forwarded funct3
//  o_is_store     out  1                forwarded store flag
//  o_wdata        out  XLEN             lane-aligned store data
//  o_rd_addr      out  5                forwarded rd
//  o_wr_en        out  1                forwarded write enable
//  o_misalign     out  1                address misaligned for access size
//  o_lane         out  $clog2(NUM_LANES) originating lane
//  o_count        out  $clog2(DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
//  - Reset (i_rst=1 at edge): count=0, rd/wr ptrs=0, all entry storage 0. After reset o_valid=0,
//    o_ready=1, all data outputs 0, o_count=0. Reset dominates flush, push and pop.
//  - Address: addr = base + imm, modulo 2^XLEN; carry discarded (0xFFFF_FFFC + 8 -> 0x0000_0004).
//  - Size from funct3[1:0]: 00 byte, 01 half, 10 word; 11 is treated as word and flagged misalign.
//  - byte_en: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<addr[1:0]; word = 4'b1111.
//  - misalign: half with addr[0]=1; word with addr[1:0]!=0. Misaligned ops are still enqueued,
//    with o_misalign=1 and o_byte_en=0000; the LSU raises the trap.
//  - wdata: byte/half = store_data << (8*addr[1:0]); word unchanged; loads carry store_data raw.
//  - o_ready = (DEPTH - count) >= NUM_LANES. Combinational from registered count only; never
//    depends on i_ready (no same-cycle pass-through of freed space).
//  - Push: when o_ready && !i_flush, every lane with i_valid=1 is written in ascending lane order
//    at consecutive wr_ptr slots; wr_ptr += popcount(i_valid). Invalid lanes leave no hole.
//    i_valid while o_ready=0 is ignored; the issue stage holds the group.
//  - Pop: o_valid = (count != 0); on o_valid && i_ready, rd_ptr++ . Outputs show the head entry.
//  - Latency: op accepted at edge N is visible on o_valid after edge N (earliest pop at cycle
//    N+1). The second lane of a group appears one cycle after the first if the LSU is always ready.
//  - Simultaneous push and pop: count_next = count + pushes - pop.
//  - Pointers wrap modulo DEPTH. count saturates by construction and never exceeds DEPTH.
//  - Flush: at the edge, count, rd_ptr and wr_ptr go to 0; same-cycle push and pop are discarded.
//    o_valid=0 on the following cycle.
//  - Outputs hold stable while o_valid && !i_ready.
// TESTING
//  1. Reset, then lane0 LW base=0x1000 imm=0x10 -> next cycle o_valid=1, o_addr=0x1010,
//     o_byte_en=1111, o_misalign=0.
//  2. Lane0 SB addr 0x2003 data 0xAB, lane1 SH addr 0x2002 data 0x1234 in one cycle, i_ready=1 ->
//     cycle+1: be=1000, wdata=0xAB000000, o_lane=0; cycle+2: be=1100, wdata=0x12340000, o_lane=1.
//  3. LW at 0x1002 and LH at 0x1001 -> both entries have o_misalign=1 and byte_en=0000.
//  4. i_ready=0; issue two full groups (DEPTH=4) -> o_count=4, o_ready=0; a third group is
//     ignored. Raise i_ready -> 4 pops in order; o_ready returns once o_count<=2.
//  5. Lane0 invalid, lane1 LBU base=0xFFFFFFFF imm=2 -> single entry, o_addr=0x00000001,
//     byte_en=0010, o_lane=1, o_count=1.
//  6. Queue holds 3 entries, assert i_flush together with a new valid group and i_ready=1 ->
//     next cycle o_count=0, o_valid=0; the new group is not enqueued. i_rst mid-drain -> same.

Source files
------------

// File: rtl/agu_multi_lane.sv
// Multi-lane address-generation unit for a multi-issue core: computes effective
// addresses, byte enables, misalignment and aligned store data, and feeds an in-order FIFO to the LSU.
module agu_multi_lane #(
  parameter int NUM_LANES = 2,
  parameter int XLEN      = 32,
  parameter int DEPTH     = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_flush,
  input  logic [NUM_LANES-1:0]         i_valid,
  input  logic [NUM_LANES*XLEN-1:0]    i_base,
  input  logic [NUM_LANES*XLEN-1:0]    i_imm,
  input  logic [NUM_LANES*3-1:0]       i_funct3,
  input  logic [NUM_LANES-1:0]         i_is_store,
  input  logic [NUM_LANES*XLEN-1:0]    i_store_data,
  input  logic [NUM_LANES*5-1:0]       i_rd_addr,
  input  logic [NUM_LANES-1:0]         i_wr_en,
  output logic                         o_ready,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [XLEN-1:0]              o_addr,
  output logic [3:0]                   o_byte_en,
  output logic [2:0]                   o_funct3,
  output logic                         o_is_store,
  output logic [XLEN-1:0]              o_wdata,
  output logic [4:0]                   o_rd_addr,
  output logic                         o_wr_en,
  output logic                         o_misalign,
  output logic [$clog2(NUM_LANES)-1:0] o_lane,
  output logic [$clog2(DEPTH):0]       o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int LW = $clog2(NUM_LANES);

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [3:0]      byte_en;
    logic [2:0]      funct3;
    logic            is_store;
    logic [XLEN-1:0] wdata;
    logic [4:0]      rd_addr;
    logic            wr_en;
    logic            misalign;
    logic [LW-1:0]   lane;
  } entry_t;

  entry_t        mem_reg [DEPTH];
  logic [PW-1:0] rd_ptr_reg;
  logic [PW-1:0] wr_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;

  entry_t        lane_entry  [NUM_LANES];
  logic [PW-1:0] lane_slot   [NUM_LANES];
  logic [CW-1:0] lane_prefix [NUM_LANES+1];

  logic          push_en;
  logic [CW-1:0] push_cnt;
  logic          pop;
  entry_t        head;

  assign lane_prefix[0] = '0;

  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      logic [XLEN-1:0] addr;
      logic [2:0]      f3;
      logic [XLEN-1:0] sdata;
      logic [3:0]      be;
      logic            mis;
      logic [XLEN-1:0] wdata;
      entry_t          ent;

      assign addr  = i_base[gi*XLEN +: XLEN] + i_imm[gi*XLEN +: XLEN];
      assign f3    = i_funct3[gi*3 +: 3];
      assign sdata = i_store_data[gi*XLEN +: XLEN];

      always_comb begin
        be    = 4'b0000;
        mis   = 1'b0;
        wdata = sdata;
        case (f3[1:0])
          2'b00: be = 4'b0001 << addr[1:0];
          2'b01: begin
            be  = 4'b0011 << addr[1:0];
            mis = addr[0];
          end
          2'b10: begin
            be  = 4'b1111;
            mis = |addr[1:0];
          end
          default: begin
            be  = 4'b1111;
            mis = 1'b1;
          end
        endcase
        // Misaligned ops travel with no byte lanes so the LSU can never write partially.
        if (mis) be = 4'b0000;
        if (i_is_store[gi] && !f3[1]) wdata = sdata << {addr[1:0], 3'b000};
      end

      always_comb begin
        ent          = '0;
        ent.addr     = addr;
        ent.byte_en  = be;
        ent.funct3   = f3;
        ent.is_store = i_is_store[gi];
        ent.wdata    = wdata;
        ent.rd_addr  = i_rd_addr[gi*5 +: 5];
        ent.wr_en    = i_wr_en[gi];
        ent.misalign = mis;
        ent.lane     = LW'(gi);
      end

      assign lane_entry[gi]    = ent;
      // Valid lanes pack into consecutive slots; older lanes take the lower slots.
      assign lane_prefix[gi+1] = lane_prefix[gi] + CW'(i_valid[gi]);
      assign lane_slot[gi]     = wr_ptr_reg + lane_prefix[gi][PW-1:0];
    end
  endgenerate

  assign o_ready    = (count_reg <= CW'(DEPTH - NUM_LANES));
  assign o_valid    = (count_reg != '0);
  assign push_en    = o_ready;
  assign push_cnt   = push_en ? lane_prefix[NUM_LANES] : '0;
  assign pop        = o_valid && i_ready;
  assign count_next = count_reg + push_cnt - CW'(pop);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_reg  <= '0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      for (int d = 0; d < DEPTH; d++) mem_reg[d] <= '0;
    end else if (i_flush) begin
      count_reg  <= '0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
    end else begin
      count_reg  <= count_next;
      rd_ptr_reg <= rd_ptr_reg + PW'(pop);
      wr_ptr_reg <= wr_ptr_reg + push_cnt[PW-1:0];
      for (int l = 0; l < NUM_LANES; l++) begin
        if (push_en && i_valid[l]) mem_reg[lane_slot[l]] <= lane_entry[l];
      end
    end
  end

  assign head       = mem_reg[rd_ptr_reg];
  assign o_addr     = head.addr;
  assign o_byte_en  = head.byte_en;
  assign o_funct3   = head.funct3;
  assign o_is_store = head.is_store;
  assign o_wdata    = head.wdata;
  assign o_rd_addr  = head.rd_addr;
  assign o_wr_en    = head.wr_en;
  assign o_misalign = head.misalign;
  assign o_lane     = head.lane;
  assign o_count    = count_reg;

endmodule
